// File: rtl/arp_table_access_ctrl_pkg.sv
// Shared types and constants for the ARP table access controller.
package arp_table_access_ctrl_pkg;

  localparam int unsigned LUT_DEPTH      = 32;
  localparam int unsigned LUT_DEPTH_BITS = 5;
  localparam int unsigned TIMEOUT_CYCLES = 64;
  localparam int unsigned WD_BITS        = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned MAC_W          = 48;
  localparam int unsigned IP_W           = 32;

  localparam logic [IP_W-1:0] ARP_IP_INVALID = 32'h0000_0000;
  localparam logic [IP_W-1:0] ARP_IP_BCAST   = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TBL_RD = 3'd1,
    ST_TBL_WR = 3'd2,
    ST_LRN_WR = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  typedef enum logic {
    GRANT_REG   = 1'b0,
    GRANT_LEARN = 1'b1
  } grant_e;

  // Only unicast, non-zero sender IPs are worth learning.
  function automatic logic learn_ip_ok(input logic [IP_W-1:0] ip);
    return (ip != ARP_IP_INVALID) && (ip != ARP_IP_BCAST);
  endfunction

endpackage

// File: rtl/arp_shadow_match.sv
// Shadow copy of table IPs/valid bits with a lowest-index-wins match encoder.
module arp_shadow_match
  import arp_table_access_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      upd_en,
  input  logic [LUT_DEPTH_BITS-1:0] upd_idx,
  input  logic [IP_W-1:0]           upd_ip,
  input  logic [IP_W-1:0]           lookup_ip,
  output logic                      hit_c,
  output logic [LUT_DEPTH_BITS-1:0] hit_idx_c
);

  logic [IP_W-1:0]      ip_q [LUT_DEPTH];
  logic [LUT_DEPTH-1:0] valid_q;

  // Writing IP 0 invalidates the slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (upd_en) begin
      ip_q[upd_idx]    <= upd_ip;
      valid_q[upd_idx] <= (upd_ip != ARP_IP_INVALID);
    end
  end

  always_comb begin
    hit_c     = 1'b0;
    hit_idx_c = '0;
    for (int i = int'(LUT_DEPTH) - 1; i >= 0; i--) begin
      if (valid_q[i] && (ip_q[i] == lookup_ip)) begin
        hit_c     = 1'b1;
        hit_idx_c = LUT_DEPTH_BITS'(i);
      end
    end
  end

endmodule

// File: rtl/arp_table_access_ctrl.sv
// Arbitrates the ip_arp table ports between host register access and ARP learning,
// one transaction at a time, with a watchdog on the table ack.
module arp_table_access_ctrl
  import arp_table_access_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      reg_rd_req,
  input  logic [LUT_DEPTH_BITS-1:0] reg_rd_addr,
  output logic [MAC_W-1:0]          reg_rd_mac,
  output logic [IP_W-1:0]           reg_rd_ip,
  output logic                      reg_rd_ack,
  input  logic                      reg_wr_req,
  input  logic [LUT_DEPTH_BITS-1:0] reg_wr_addr,
  input  logic [MAC_W-1:0]          reg_wr_mac,
  input  logic [IP_W-1:0]           reg_wr_ip,
  output logic                      reg_wr_ack,
  input  logic                      learn_vld,
  input  logic [IP_W-1:0]           learn_ip,
  input  logic [MAC_W-1:0]          learn_mac,
  output logic                      learn_done,
  output logic [LUT_DEPTH_BITS-1:0] learn_idx,
  output logic                      arp_rd_req,
  output logic [LUT_DEPTH_BITS-1:0] arp_rd_addr,
  input  logic [MAC_W-1:0]          arp_rd_mac,
  input  logic [IP_W-1:0]           arp_rd_ip,
  input  logic                      arp_rd_ack,
  output logic                      arp_wr_req,
  output logic [LUT_DEPTH_BITS-1:0] arp_wr_addr,
  output logic [MAC_W-1:0]          arp_wr_mac,
  output logic [IP_W-1:0]           arp_wr_ip,
  input  logic                      arp_wr_ack,
  output logic                      timeout_err
);

  state_e                      state_q, state_n;
  grant_e                      last_grant_q, last_grant_n;
  logic [LUT_DEPTH_BITS-1:0]   victim_q, victim_n;
  logic [WD_BITS-1:0]          wd_q, wd_n;
  logic                        cur_hit_q, cur_hit_n;

  logic [MAC_W-1:0]            reg_rd_mac_n;
  logic [IP_W-1:0]             reg_rd_ip_n;
  logic                        reg_rd_ack_n, reg_wr_ack_n, learn_done_n, timeout_err_n;
  logic [LUT_DEPTH_BITS-1:0]   learn_idx_n, arp_rd_addr_n, arp_wr_addr_n;
  logic                        arp_rd_req_n, arp_wr_req_n;
  logic [MAC_W-1:0]            arp_wr_mac_n;
  logic [IP_W-1:0]             arp_wr_ip_n;

  logic                        shadow_upd_c;
  logic                        hit_c;
  logic [LUT_DEPTH_BITS-1:0]   hit_idx_c;
  logic                        pick_learn_c;
  logic                        wd_expired_c;

  arp_shadow_match u_shadow (
    .clk       (clk),
    .reset     (reset),
    .upd_en    (shadow_upd_c),
    .upd_idx   (arp_wr_addr),
    .upd_ip    (arp_wr_ip),
    .lookup_ip (learn_ip),
    .hit_c     (hit_c),
    .hit_idx_c (hit_idx_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_LEARN;
      victim_q     <= '0;
      wd_q         <= '0;
      cur_hit_q    <= 1'b0;
      reg_rd_mac   <= '0;
      reg_rd_ip    <= '0;
      reg_rd_ack   <= 1'b0;
      reg_wr_ack   <= 1'b0;
      learn_done   <= 1'b0;
      learn_idx    <= '0;
      arp_rd_req   <= 1'b0;
      arp_rd_addr  <= '0;
      arp_wr_req   <= 1'b0;
      arp_wr_addr  <= '0;
      arp_wr_mac   <= '0;
      arp_wr_ip    <= '0;
      timeout_err  <= 1'b0;
    end else begin
      state_q      <= state_n;
      last_grant_q <= last_grant_n;
      victim_q     <= victim_n;
      wd_q         <= wd_n;
      cur_hit_q    <= cur_hit_n;
      reg_rd_mac   <= reg_rd_mac_n;
      reg_rd_ip    <= reg_rd_ip_n;
      reg_rd_ack   <= reg_rd_ack_n;
      reg_wr_ack   <= reg_wr_ack_n;
      learn_done   <= learn_done_n;
      learn_idx    <= learn_idx_n;
      arp_rd_req   <= arp_rd_req_n;
      arp_rd_addr  <= arp_rd_addr_n;
      arp_wr_req   <= arp_wr_req_n;
      arp_wr_addr  <= arp_wr_addr_n;
      arp_wr_mac   <= arp_wr_mac_n;
      arp_wr_ip    <= arp_wr_ip_n;
      timeout_err  <= timeout_err_n;
    end
  end

  always_comb begin
    state_n       = state_q;
    last_grant_n  = last_grant_q;
    victim_n      = victim_q;
    wd_n          = wd_q;
    cur_hit_n     = cur_hit_q;
    reg_rd_mac_n  = reg_rd_mac;
    reg_rd_ip_n   = reg_rd_ip;
    learn_idx_n   = learn_idx;
    arp_rd_req_n  = arp_rd_req;
    arp_rd_addr_n = arp_rd_addr;
    arp_wr_req_n  = arp_wr_req;
    arp_wr_addr_n = arp_wr_addr;
    arp_wr_mac_n  = arp_wr_mac;
    arp_wr_ip_n   = arp_wr_ip;
    reg_rd_ack_n  = 1'b0;
    reg_wr_ack_n  = 1'b0;
    learn_done_n  = 1'b0;
    timeout_err_n = 1'b0;
    shadow_upd_c  = 1'b0;

    // Learn wins when alone, or on a tie when REG had the previous grant.
    pick_learn_c = learn_vld && (!(reg_wr_req || reg_rd_req) || (last_grant_q == GRANT_REG));
    // Counter is 1 in the first request cycle, so abort pulses land 64 cycles after grant.
    wd_expired_c = (wd_q == WD_BITS'(TIMEOUT_CYCLES - 1));

    case (state_q)
      ST_IDLE: begin
        if (pick_learn_c) begin
          last_grant_n = GRANT_LEARN;
          if (learn_ip_ok(learn_ip)) begin
            state_n       = ST_LRN_WR;
            arp_wr_req_n  = 1'b1;
            arp_wr_addr_n = hit_c ? hit_idx_c : victim_q;
            arp_wr_mac_n  = learn_mac;
            arp_wr_ip_n   = learn_ip;
            cur_hit_n     = hit_c;
            wd_n          = WD_BITS'(1);
          end else begin
            state_n      = ST_RESP;
            learn_done_n = 1'b1;
            learn_idx_n  = '0;
          end
        end else if (reg_wr_req) begin
          last_grant_n  = GRANT_REG;
          state_n       = ST_TBL_WR;
          arp_wr_req_n  = 1'b1;
          arp_wr_addr_n = reg_wr_addr;
          arp_wr_mac_n  = reg_wr_mac;
          arp_wr_ip_n   = reg_wr_ip;
          wd_n          = WD_BITS'(1);
        end else if (reg_rd_req) begin
          last_grant_n  = GRANT_REG;
          state_n       = ST_TBL_RD;
          arp_rd_req_n  = 1'b1;
          arp_rd_addr_n = reg_rd_addr;
          wd_n          = WD_BITS'(1);
        end
      end

      ST_TBL_RD: begin
        if (arp_rd_ack) begin
          state_n      = ST_RESP;
          arp_rd_req_n = 1'b0;
          reg_rd_ack_n = 1'b1;
          reg_rd_mac_n = arp_rd_mac;
          reg_rd_ip_n  = arp_rd_ip;
        end else if (wd_expired_c) begin
          state_n       = ST_RESP;
          arp_rd_req_n  = 1'b0;
          reg_rd_ack_n  = 1'b1;
          reg_rd_mac_n  = '0;
          reg_rd_ip_n   = '0;
          timeout_err_n = 1'b1;
        end else begin
          wd_n = wd_q + 1'b1;
        end
      end

      ST_TBL_WR, ST_LRN_WR: begin
        if (arp_wr_ack) begin
          state_n      = ST_RESP;
          arp_wr_req_n = 1'b0;
          shadow_upd_c = 1'b1;
          if (state_q == ST_TBL_WR) begin
            reg_wr_ack_n = 1'b1;
          end else begin
            learn_done_n = 1'b1;
            learn_idx_n  = arp_wr_addr;
            if (!cur_hit_q) begin
              victim_n = (victim_q == LUT_DEPTH_BITS'(LUT_DEPTH - 1)) ? '0 : victim_q + 1'b1;
            end
          end
        end else if (wd_expired_c) begin
          state_n       = ST_RESP;
          arp_wr_req_n  = 1'b0;
          timeout_err_n = 1'b1;
          if (state_q == ST_TBL_WR) begin
            reg_wr_ack_n = 1'b1;
          end else begin
            learn_done_n = 1'b1;
            learn_idx_n  = '0;
          end
        end else begin
          wd_n = wd_q + 1'b1;
        end
      end

      ST_RESP: state_n = ST_IDLE;

      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_arp_table_access_ctrl.sv
// Scoreboard bench for arp_table_access_ctrl with a behavioural ip_arp table model.
module tb_arp_table_access_ctrl;

  localparam int K_WR  = 0;
  localparam int K_RD  = 1;
  localparam int K_LRN = 2;

  typedef struct {
    int          kind;
    logic [4:0]  idx;
    logic [31:0] ip;
    logic [47:0] mac;
    logic        to;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reg_rd_req = 1'b0;
  logic [4:0]  reg_rd_addr = '0;
  logic [47:0] reg_rd_mac;
  logic [31:0] reg_rd_ip;
  logic        reg_rd_ack;
  logic        reg_wr_req = 1'b0;
  logic [4:0]  reg_wr_addr = '0;
  logic [47:0] reg_wr_mac = '0;
  logic [31:0] reg_wr_ip = '0;
  logic        reg_wr_ack;
  logic        learn_vld = 1'b0;
  logic [31:0] learn_ip = '0;
  logic [47:0] learn_mac = '0;
  logic        learn_done;
  logic [4:0]  learn_idx;
  logic        arp_rd_req;
  logic [4:0]  arp_rd_addr;
  logic [47:0] arp_rd_mac = '0;
  logic [31:0] arp_rd_ip = '0;
  logic        arp_rd_ack = 1'b0;
  logic        arp_wr_req;
  logic [4:0]  arp_wr_addr;
  logic [47:0] arp_wr_mac;
  logic [31:0] arp_wr_ip;
  logic        arp_wr_ack = 1'b0;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  logic        ack_en = 1'b1;
  int          ack_delay = 1;
  int          late_req = 0;
  int          late_done = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic [31:0] tbl_ip  [32];
  logic [47:0] tbl_mac [32];

  int lat_a, lat_b, reqc_a, reqc_b;

  arp_table_access_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .reg_rd_req  (reg_rd_req),
    .reg_rd_addr (reg_rd_addr),
    .reg_rd_mac  (reg_rd_mac),
    .reg_rd_ip   (reg_rd_ip),
    .reg_rd_ack  (reg_rd_ack),
    .reg_wr_req  (reg_wr_req),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_mac  (reg_wr_mac),
    .reg_wr_ip   (reg_wr_ip),
    .reg_wr_ack  (reg_wr_ack),
    .learn_vld   (learn_vld),
    .learn_ip    (learn_ip),
    .learn_mac   (learn_mac),
    .learn_done  (learn_done),
    .learn_idx   (learn_idx),
    .arp_rd_req  (arp_rd_req),
    .arp_rd_addr (arp_rd_addr),
    .arp_rd_mac  (arp_rd_mac),
    .arp_rd_ip   (arp_rd_ip),
    .arp_rd_ack  (arp_rd_ack),
    .arp_wr_req  (arp_wr_req),
    .arp_wr_addr (arp_wr_addr),
    .arp_wr_mac  (arp_wr_mac),
    .arp_wr_ip   (arp_wr_ip),
    .arp_wr_ack  (arp_wr_ack),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // ip_arp model: acks the ack_delay-th cycle a request is seen; late_req injects a stray ack.
  always @(negedge clk) begin
    arp_wr_ack = 1'b0;
    arp_rd_ack = 1'b0;
    if (arp_wr_req) begin
      wr_cnt = wr_cnt + 1;
      if (ack_en && wr_cnt == ack_delay) begin
        arp_wr_ack = 1'b1;
        tbl_ip[arp_wr_addr]  = arp_wr_ip;
        tbl_mac[arp_wr_addr] = arp_wr_mac;
      end
    end else begin
      wr_cnt = 0;
      if (late_req != late_done) begin
        arp_wr_ack = 1'b1;
        late_done  = late_done + 1;
      end
    end
    if (arp_rd_req) begin
      rd_cnt = rd_cnt + 1;
      if (ack_en && rd_cnt == ack_delay) begin
        arp_rd_ack = 1'b1;
        arp_rd_mac = tbl_mac[arp_rd_addr];
        arp_rd_ip  = tbl_ip[arp_rd_addr];
      end
    end else begin
      rd_cnt = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  function automatic void push(input int k, input logic [4:0] idx, input logic [31:0] ip,
                               input logic [47:0] mac, input logic to);
    exp_t e;
    e.kind = k;
    e.idx  = idx;
    e.ip   = ip;
    e.mac  = mac;
    e.to   = to;
    sb.push_back(e);
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Pops one expectation per requester pulse.
  task automatic monitor();
    exp_t e;
    int   kind;
    int   npulse;
    forever begin
      @(negedge clk);
      npulse = int'(reg_wr_ack) + int'(reg_rd_ack) + int'(learn_done);
      if (npulse != 0) begin
        kind = reg_wr_ack ? K_WR : (reg_rd_ack ? K_RD : K_LRN);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected: kind=%0d idx=%0d to=%b, required no response", kind, learn_idx, timeout_err);
        end else begin
          e = sb.pop_front();
          if (npulse != 1 || kind != e.kind || timeout_err != e.to ||
              (kind == K_RD && (reg_rd_mac != e.mac || reg_rd_ip != e.ip)) ||
              (kind == K_LRN && learn_idx != e.idx)) begin
            errors++;
            $display("FAIL resp: got kind=%0d pulses=%0d to=%b idx=%0d ip=%h mac=%h, required kind=%0d to=%b idx=%0d ip=%h mac=%h",
                     kind, npulse, timeout_err, learn_idx, reg_rd_ip, reg_rd_mac, e.kind, e.to, e.idx, e.ip, e.mac);
          end
        end
      end else if (timeout_err) begin
        checks++;
        errors++;
        $display("FAIL timeout_orphan: timeout_err=1 without ack/done, required 0");
      end
    end
  endtask

  task automatic req_wr(input logic [4:0] a, input logic [31:0] ip, input logic [47:0] mac,
                        output int lat, output int reqc);
    reg_wr_addr = a; reg_wr_ip = ip; reg_wr_mac = mac; reg_wr_req = 1'b1;
    lat = 0; reqc = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (arp_wr_req) reqc++;
      if (reg_wr_ack) begin lat = n; break; end
    end
    reg_wr_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic req_rd(input logic [4:0] a, output int lat);
    reg_rd_addr = a; reg_rd_req = 1'b1;
    lat = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (reg_rd_ack) begin lat = n; break; end
    end
    reg_rd_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic req_learn(input logic [31:0] ip, input logic [47:0] mac, output int lat, output int reqc);
    learn_ip = ip; learn_mac = mac; learn_vld = 1'b1;
    lat = 0; reqc = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (arp_wr_req) reqc++;
      if (learn_done) begin lat = n; break; end
    end
    learn_vld = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic any_out();
    return |{reg_rd_mac, reg_rd_ip, reg_rd_ack, reg_wr_ack, learn_done, learn_idx, arp_rd_req,
             arp_rd_addr, arp_wr_req, arp_wr_addr, arp_wr_mac, arp_wr_ip, timeout_err};
  endfunction

  initial begin
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'(any_out()), 0);
    reset = 1'b0;
    @(negedge clk);

    // Host write, table acks on the second request cycle.
    ack_delay = 2;
    push(K_WR, 5'd0, 32'h0, 48'h0, 1'b0);
    req_wr(5'd3, 32'h0A00_0001, 48'h0011_2233_4455, lat_a, reqc_a);
    chk("t1_req_cycles", reqc_a, 2);
    chk("t1_ack_latency", lat_a, 3);
    chk("t1_table_ip", 64'(tbl_ip[3]), 64'h0A00_0001);
    ack_delay = 1;

    // Learn hits the host-written entry.
    push(K_LRN, 5'd3, 32'h0, 48'h0, 1'b0);
    req_learn(32'h0A00_0001, 48'h0A0A_0A0A_0A0A, lat_a, reqc_a);
    chk("t2_learn_latency", lat_a, 2);
    chk("t2_table_mac", 64'(tbl_mac[3]), 64'h0A0A_0A0A_0A0A);
    push(K_WR, 5'd0, 32'h0, 48'h0, 1'b0);
    req_wr(5'd3, 32'h0, 48'h0, lat_a, reqc_a);

    // 33 misses: slots 0..31, then wrap to 0.
    for (int i = 0; i <= 32; i++) begin
      push(K_LRN, 5'(i % 32), 32'h0, 48'h0, 1'b0);
      req_learn(32'hC0A8_0000 + 32'(i), 48'h0200_0000_0000 + 48'(i), lat_a, reqc_a);
    end
    chk("t3_wrap_table_ip", 64'(tbl_ip[0]), 64'hC0A8_0020);

    // Simultaneous REG/LEARN: last grant was LEARN, so REG goes first each round.
    push(K_RD, 5'd0, 32'hC0A8_0005, 48'h0200_0000_0005, 1'b0);
    push(K_LRN, 5'd7, 32'h0, 48'h0, 1'b0);
    fork
      req_rd(5'd5, lat_a);
      req_learn(32'hC0A8_0007, 48'h0B00_0000_0007, lat_b, reqc_b);
    join
    chk("t4_rd_latency", lat_a, 2);
    chk("t4_learn_latency", lat_b, 5);
    push(K_RD, 5'd0, 32'hC0A8_0020, 48'h0200_0000_0020, 1'b0);
    push(K_LRN, 5'd9, 32'h0, 48'h0, 1'b0);
    fork
      req_rd(5'd0, lat_a);
      req_learn(32'hC0A8_0009, 48'h0B00_0000_0009, lat_b, reqc_b);
    join
    chk("t4_round2_learn_latency", lat_b, 5);

    // After a lone REG grant, LEARN wins the next tie.
    push(K_RD, 5'd0, 32'hC0A8_001F, 48'h0200_0000_001F, 1'b0);
    req_rd(5'd31, lat_a);
    push(K_LRN, 5'd10, 32'h0, 48'h0, 1'b0);
    push(K_RD, 5'd0, 32'hC0A8_0006, 48'h0200_0000_0006, 1'b0);
    fork
      req_rd(5'd6, lat_a);
      req_learn(32'hC0A8_000A, 48'h0B00_0000_000A, lat_b, reqc_b);
    join
    chk("t4b_learn_latency", lat_b, 2);
    chk("t4b_rd_latency", lat_a, 5);

    // Watchdog abort on a learn; stray late ack must be ignored.
    ack_en = 1'b0;
    push(K_LRN, 5'd0, 32'h0, 48'h0, 1'b1);
    req_learn(32'h0B00_0001, 48'h0C00_0000_0001, lat_a, reqc_a);
    chk("t5_timeout_latency", lat_a, 64);
    chk("t5_timeout_req_cycles", reqc_a, 63);
    ack_en = 1'b1;
    late_req = late_req + 1;
    repeat (4) @(negedge clk);
    push(K_LRN, 5'd1, 32'h0, 48'h0, 1'b0);
    req_learn(32'h0B00_0001, 48'h0C00_0000_0001, lat_a, reqc_a);
    push(K_LRN, 5'd2, 32'h0, 48'h0, 1'b0);
    req_learn(32'h0B00_0002, 48'h0C00_0000_0002, lat_a, reqc_a);
    push(K_LRN, 5'd1, 32'h0, 48'h0, 1'b0);
    req_learn(32'h0B00_0001, 48'h0C00_0000_0001, lat_a, reqc_a);

    // Unlearnable IPs are dropped without touching the table.
    push(K_LRN, 5'd0, 32'h0, 48'h0, 1'b0);
    req_learn(32'h0, 48'h0D00_0000_0000, lat_a, reqc_a);
    chk("t6_zero_ip_latency", lat_a, 1);
    chk("t6_zero_ip_no_wr", reqc_a, 0);
    push(K_LRN, 5'd0, 32'h0, 48'h0, 1'b0);
    req_learn(32'hFFFF_FFFF, 48'h0D00_0000_0001, lat_a, reqc_a);
    chk("t6_bcast_latency", lat_a, 1);
    chk("t6_bcast_no_wr", reqc_a, 0);

    // Reset in the middle of a table read.
    ack_en = 1'b0;
    reg_rd_addr = 5'd2;
    reg_rd_req = 1'b1;
    lat_a = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (arp_rd_req) begin lat_a = n; break; end
    end
    chk("t6_rd_req_raised", 64'(arp_rd_req), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rd_req_after_reset", 64'(arp_rd_req), 0);
    chk("t6_no_rd_ack_after_reset", 64'(reg_rd_ack), 0);
    chk("t6_outputs_after_reset", 64'(any_out()), 0);
    reg_rd_req = 1'b0;
    ack_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // After reset: REG wins the first tie, shadow is empty so the learn takes slot 0.
    push(K_RD, 5'd0, 32'h0B00_0001, 48'h0C00_0000_0001, 1'b0);
    push(K_LRN, 5'd0, 32'h0, 48'h0, 1'b0);
    fork
      req_rd(5'd1, lat_a);
      req_learn(32'hC0A8_0005, 48'h0E00_0000_0005, lat_b, reqc_b);
    join
    chk("t6_post_reset_learn_latency", lat_b, 5);

    for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
